// File: rtl/gbsha_fir_pkg.sv
// Shared widths, state encoding and width helpers for the gbsha sign-magnitude FIR.
// Optional build macro FIR_SATURATE_EN affects only gbsha_fir_taps.
package gbsha_fir_pkg;

  localparam int DEF_N_TAPS     = 4;
  localparam int DEF_BW_IN      = 6;
  localparam int DEF_BW_PRODUCT = 12;
  localparam int DEF_BW_OUT     = 8;
  localparam int DEF_OUT_SHIFT  = 0;

  // Sign-magnitude sample layout: one sign bit on top of the magnitude.
  localparam int SM_SIGN_W = 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fir_state_t;

  function automatic int sm_mag_w(input int bw_in);
    return bw_in - SM_SIGN_W;
  endfunction

  // Sum of n_taps products of bw_product bits cannot exceed this width.
  function automatic int bw_acc(input int bw_product, input int n_taps);
    return bw_product + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/gbsha_fir_taps_if.sv
// Sample/result bus of gbsha_fir_taps plus the FSM state for checkers.
// One sample per clock, no valid/ready: x_in is consumed every edge, y_out and loaded are registered.
interface gbsha_fir_taps_if
  import gbsha_fir_pkg::*;
#(
  parameter int BW_in  = DEF_BW_IN,
  parameter int BW_out = DEF_BW_OUT
) ();

  logic [BW_in-1:0]  x_in;
  logic [BW_out-1:0] y_out;
  logic              loaded;
  fir_state_t        dbg_state;

  modport master (
    output x_in,
    input  y_out,
    input  loaded,
    input  dbg_state
  );

  modport slave (
    input  x_in,
    output y_out,
    output loaded,
    output dbg_state
  );

endinterface

// File: rtl/gbsha_sm_mult.sv
// Combinational sign-magnitude x sign-magnitude multiply to a signed two's-complement product.
module gbsha_sm_mult
  import gbsha_fir_pkg::*;
#(
  parameter int BW_in      = DEF_BW_IN,
  parameter int BW_product = DEF_BW_PRODUCT
) (
  input  logic [BW_in-1:0]             a,
  input  logic [BW_in-1:0]             b,
  output logic signed [BW_product-1:0] p
);

  localparam int MAG_W = sm_mag_w(BW_in);

  logic [2*MAG_W-1:0]           mag_prod;
  logic                         neg;
  logic signed [BW_product-1:0] mag_ext;

  assign mag_prod = a[MAG_W-1:0] * b[MAG_W-1:0];
  assign neg      = a[BW_in-1] ^ b[BW_in-1];
  assign mag_ext  = {{(BW_product-2*MAG_W){1'b0}}, mag_prod};

  // A zero magnitude on either side (including negative zero) always yields +0.
  assign p = (neg && (mag_prod != '0)) ? -mag_ext : mag_ext;

endmodule

// File: rtl/gbsha_fir_taps.sv
// N-tap direct-form FIR: loads N_TAPS sign-magnitude coefficients after reset, then filters one sample per clock.
// Build macro FIR_SATURATE_EN clamps the output instead of wrapping it.
module gbsha_fir_taps
  import gbsha_fir_pkg::*;
#(
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int BW_in      = DEF_BW_IN,
  parameter int BW_product = DEF_BW_PRODUCT,
  parameter int BW_out     = DEF_BW_OUT,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  gbsha_fir_taps_if.slave  bus
);

  localparam int BW_ACC = bw_acc(BW_product, N_TAPS);
  localparam int CNT_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  fir_state_t                   state;
  logic [CNT_W-1:0]             cnt;
  logic [BW_in-1:0]             coef  [N_TAPS];
  logic [BW_in-1:0]             dly   [N_TAPS];
  logic signed [BW_product-1:0] prod  [N_TAPS];
  logic signed [BW_ACC-1:0]     acc;
  logic signed [BW_ACC-1:0]     acc_sh;
  logic [BW_out-1:0]            y_next;
  logic [BW_out-1:0]            y_q;
  logic                         loaded_q;

  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    gbsha_sm_mult #(
      .BW_in      (BW_in),
      .BW_product (BW_product)
    ) u_mult (
      .a (coef[i]),
      .b (dly[i]),
      .p (prod[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      acc = acc + BW_ACC'(prod[i]);
    end
  end

  assign acc_sh = acc >>> OUT_SHIFT;

`ifdef FIR_SATURATE_EN
  localparam logic signed [BW_ACC-1:0] SAT_MAX = BW_ACC'((1 << (BW_out - 1)) - 1);
  localparam logic signed [BW_ACC-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    y_next = BW_out'(acc_sh);
    if (acc_sh > SAT_MAX) begin
      y_next = BW_out'(SAT_MAX);
    end else if (acc_sh < SAT_MIN) begin
      y_next = BW_out'(SAT_MIN);
    end
  end
`else
  always_comb begin
    y_next = BW_out'(acc_sh);
  end
`endif

  // LOAD fills coef[] in order with the delay line held at zero; RUN never exits except on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      cnt      <= '0;
      y_q      <= '0;
      loaded_q <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        coef[i] <= '0;
        dly[i]  <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          coef[cnt] <= bus.x_in;
          if (cnt == CNT_W'(N_TAPS - 1)) begin
            state    <= ST_RUN;
            loaded_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          dly[0] <= bus.x_in;
          for (int i = 1; i < N_TAPS; i++) begin
            dly[i] <= dly[i-1];
          end
          y_q <= y_next;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign bus.y_out     = y_q;
  assign bus.loaded    = loaded_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_gbsha_fir_taps.sv
// Directed bench for gbsha_fir_taps with hand-computed expected outputs (default parameters).
// Expected overflow values follow FIR_SATURATE_EN when it is defined for the build.
module tb_gbsha_fir_taps;
  import gbsha_fir_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset;

  gbsha_fir_taps_if #(.BW_in(6), .BW_out(8)) bus ();

  gbsha_fir_taps #(
    .N_TAPS     (4),
    .BW_in      (6),
    .BW_product (12),
    .BW_out     (8),
    .OUT_SHIFT  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.x_in = 6'h15;
    tick();
    reset = 1'b0;
    check_eq("reset_y", 32'(bus.y_out), 32'h0);
    check_eq("reset_loaded", 32'(bus.loaded), 32'h0);
    check_eq("reset_state", 32'(bus.dbg_state), 32'(ST_LOAD));
  endtask

  task automatic load4(input string tag, input logic [5:0] c0, input logic [5:0] c1,
                       input logic [5:0] c2, input logic [5:0] c3);
    logic [5:0] cs [4];
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    for (int i = 0; i < 4; i++) begin
      bus.x_in = cs[i];
      tick();
      check_eq({tag, "_load_y"}, 32'(bus.y_out), 32'h0);
      check_eq({tag, "_loaded"}, 32'(bus.loaded), (i == 3) ? 32'h1 : 32'h0);
    end
    check_eq({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_RUN));
  endtask

  // scoreboard: one edge per queued value with x_in held
  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_eq(tag, 32'(bus.y_out), 32'(e));
    end
  endtask

  task automatic step_sample(input string tag, input logic [5:0] x, input logic [W-1:0] e);
    bus.x_in = x;
    tick();
    check_eq(tag, 32'(bus.y_out), 32'(e));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.x_in = '0;
    tick();

    // impulse response, also shows load values never reach the delay line
    do_reset();
    load4("imp", 6'h01, 6'h02, 6'h03, 6'h04);
    step_sample("imp_first", 6'h01, 8'h00);
    bus.x_in = 6'h00;
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    exp_q.push_back(8'd4); exp_q.push_back(8'd0);
    drain("imp_y");

    // step response
    do_reset();
    load4("step", 6'h01, 6'h02, 6'h03, 6'h04);
    bus.x_in = 6'h02;
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd6);
    exp_q.push_back(8'd12); exp_q.push_back(8'd20); exp_q.push_back(8'd20);
    drain("step_y");

    // signs and negative zero, c0 = -1
    do_reset();
    load4("sgn", 6'h21, 6'h00, 6'h00, 6'h00);
    step_sample("sgn_lat", 6'h05, 8'h00);
    step_sample("sgn_pos_x", 6'h25, 8'hFB);
    step_sample("sgn_neg_x", 6'h20, 8'h05);
    step_sample("sgn_negzero", 6'h00, 8'h00);

    // overflow: 961 per tap, steady 3844 = 0xF04
    do_reset();
    load4("ovf", 6'h1F, 6'h1F, 6'h1F, 6'h1F);
    bus.x_in = 6'h1F;
`ifdef FIR_SATURATE_EN
    exp_q.push_back(8'h00); exp_q.push_back(8'h7F); exp_q.push_back(8'h7F);
    exp_q.push_back(8'h7F); exp_q.push_back(8'h7F); exp_q.push_back(8'h7F);
`else
    exp_q.push_back(8'h00); exp_q.push_back(8'hC1); exp_q.push_back(8'h82);
    exp_q.push_back(8'h43); exp_q.push_back(8'h04); exp_q.push_back(8'h04);
`endif
    drain("ovf_pos");
    bus.x_in = 6'h3F;
    for (int i = 0; i < 5; i++) tick();
`ifdef FIR_SATURATE_EN
    check_eq("ovf_neg", 32'(bus.y_out), 32'h80);
`else
    check_eq("ovf_neg", 32'(bus.y_out), 32'hFC);
`endif

    // reset mid-run, then reload with coefficients that would expose stale delay data
    do_reset();
    load4("rld", 6'h02, 6'h1F, 6'h1F, 6'h1F);
    step_sample("rld_first", 6'h03, 8'h00);
    step_sample("rld_c0", 6'h00, 8'h06);
    step_sample("rld_c1", 6'h00, 8'h5D);

    // reset mid-load restarts coefficient loading at c[0]
    do_reset();
    bus.x_in = 6'h1F; tick();
    bus.x_in = 6'h1F; tick();
    check_eq("midload_loaded", 32'(bus.loaded), 32'h0);
    do_reset();
    load4("midload", 6'h03, 6'h00, 6'h00, 6'h00);
    step_sample("midload_first", 6'h22, 8'h00);
    step_sample("midload_c0", 6'h00, 8'hFA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gbsha_fir_taps.md
Name: gbsha_fir_taps

Overview:
Parametrised N-tap direct-form FIR for the 8-bit tile I/O. Inputs are sign-magnitude. After reset it loads N_TAPS coefficients serially from the sample bus, then filters one sample per clock. It is the multi-tap successor of the single-tap sign-magnitude multiplier. It sits behind the top-level pin wrapper: clk=io_in[0], reset=io_in[1], x_in=io_in[7:2], y_out=io_out.

Parameters:
N_TAPS, 4, number of taps and coefficients (>=1)
BW_in, 6, input width; MSB is the sign, lower BW_in-1 bits are the magnitude
BW_product, 12, signed two's-complement product width (>= 2*(BW_in-1)+1)
BW_out, 8, output width (<=8)
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
x_in  input  BW_in  sign-magnitude sample, or coefficient while loading
y_out  output  BW_out  two's-complement filter output, registered
loaded  output  1  high once all coefficients are loaded (RUN state)

Behaviour:
- Reset is sampled on the rising edge of clk. Resulting state: LOAD, load counter 0, all coefficients 0, delay line 0, y_out 0, loaded 0.
- LOAD state:
  - Each edge stores x_in as c[cnt]; c[0] is loaded first. cnt increments.
  - On the edge that stores c[N_TAPS-1], go to RUN; loaded=1 after that edge.
  - The delay line stays 0 and y_out stays 0 throughout LOAD.
- RUN state:
  - Each edge shifts the delay line: d[0]<=x_in, d[i]<=d[i-1].
  - Each edge also updates y_out from the pre-edge delay line contents.
  - No exit from RUN except reset. No back-pressure and no stall.
- Latency:
  - A sample presented before edge t enters d[0] at edge t.
  - Its contribution appears on y_out after edge t+1, i.e. 2-cycle latency.
  - y(n) = sum over i of c[i]*x(n-i).
- Arithmetic:
  - Magnitudes are multiplied unsigned.
  - The product is negated when the XOR of the sign bits is 1, then sign-extended to BW_product.
  - Negative zero (sign=1, magnitude=0) yields product 0.
  - Accumulator width: BW_acc = BW_product + clog2(N_TAPS). It cannot overflow.
  - Output = (acc >>> OUT_SHIFT), reduced to BW_out bits (wrap by truncation unless the optional feature is enabled).
- N_TAPS=1 degenerates to one coefficient load followed by a registered multiply.
- Reset mid-LOAD or mid-RUN: full return to the reset state at that edge. Coefficients must be reloaded.

Optional Feature:
- Macro FIR_SATURATE_EN.
- Defined: the shifted accumulator is clamped to [-2^(BW_out-1), 2^(BW_out-1)-1] before output.
- Undefined: the low BW_out bits are output (two's-complement wrap).
- Nothing else changes.

Decomposition:
- Package gbsha_fir_pkg holds:
  - default widths;
  - a function computing BW_acc;
  - the state encoding (LOAD=1'b0, RUN=1'b1);
  - the sign-magnitude field widths.
- Sub-module gbsha_sm_mult: combinational sign-magnitude x sign-magnitude multiply producing a signed BW_product result, including the negative-zero rule. It is instantiated N_TAPS times.

Test Plan (defaults: N_TAPS=4, BW_in=6, BW_out=8, OUT_SHIFT=0):
- Impulse: load 0x01,0x02,0x03,0x04, then x=0x01 once followed by 0x00.
  -> loaded=1 after the 4th load edge; y_out = 1,2,3,4,0 on successive cycles starting 2 edges after the impulse.
- Step: same coefficients, x=0x02 held.
  -> y_out = 2,6,12,20,20,...
- Signs and negative zero: load 0x21,0,0,0.
  -> x=0x05 gives y_out=0xFB (-5); x=0x25 gives 0x05; x=0x20 gives 0x00.
- Overflow: load 0x1F x4, x=0x1F held (acc=3844).
  -> steady y_out=0x04 without FIR_SATURATE_EN, 0x7F with it.
  -> with x=0x3F held: 0xFC without the macro, 0x80 with it.
- Reset mid-run: assert reset for 1 edge during RUN.
  -> y_out=0 and loaded=0 after that edge; the next 4 x_in values are taken as new coefficients and no output appears before reload completes.
- Load-phase isolation: during LOAD present nonzero values.
  -> y_out stays 0 and the delay line is empty; the first RUN sample yields exactly c[0]*x.
